// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial frame transmitter.
// Holds the FSM state enum, sync pattern and counter width helper.
package seq_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    PAR,
    GAP
  } seq_tx_state_t;

  localparam int SYNC_LEN = 3;
  localparam logic [SYNC_LEN-1:0] SYNC_PAT = 3'b101;

  // Counter must hold DATA_W-1, GAP_LEN-1 and the sync index,
  // so it never drops below 2 bits.
  function automatic int cnt_w(input int dw, input int gl);
    int m;
    int w;
    m = (dw > gl) ? dw : gl;
    w = $clog2(m + 1);
    return (w < 2) ? 2 : w;
  endfunction

endpackage

// File: rtl/seq_pattern_tx_if.sv
// Word handshake bundle feeding the serial frame transmitter.
// master drives in_valid/in_data, slave returns in_ready.
interface seq_pattern_tx_if #(
  parameter int DATA_W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface

// File: rtl/seq_tx_shifter.sv
// Load / shift-left register holding the payload word in flight.
// Ports: clk, areset (async high), load, shift, din, msb.
module seq_tx_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              areset,
  input  logic              load,
  input  logic              shift,
  input  logic [DATA_W-1:0] din,
  output logic              msb
);

  logic [DATA_W-1:0] sh_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      sh_q <= '0;
    end else if (load) begin
      sh_q <= din;
    end else if (shift) begin
      sh_q <= sh_q << 1;
    end
  end

  assign msb = sh_q[DATA_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: sync 1-0-1, payload MSB first,
// optional parity (SEQ_PATTERN_TX_PARITY_EN), then zero gap.
// Ports: clk, areset (async high), in_if (slave handshake),
// x_out (serial bit), busy, frame_done (last frame bit pulse).
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int GAP_LEN = 2
) (
  input  logic              clk,
  input  logic              areset,
  seq_pattern_tx_if.slave   in_if,
  output logic              x_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = cnt_w(DATA_W, GAP_LEN);

`ifdef SEQ_PATTERN_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // frame_done rides the data LSB only when no parity follows.
  localparam bit LSB_DONE = !PAR_EN;

  seq_tx_state_t    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             shift;
  logic             msb;
  logic [1:0]       sidx;

  assign in_if.in_ready = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign accept         = in_if.in_valid && in_if.in_ready;

  // Shift when the current MSB is consumed onto x_out.
  assign shift = ((state_q == SYNC) && (cnt_q == '0)) ||
                 ((state_q == DATA) && (cnt_q != '0));

  // Sync bit shown next, counting down through the pattern.
  assign sidx = cnt_q[1:0] - 2'd1;

  seq_tx_shifter #(
    .DATA_W (DATA_W)
  ) u_shifter (
    .clk    (clk),
    .areset (areset),
    .load   (accept),
    .shift  (shift),
    .din    (in_if.in_data),
    .msb    (msb)
  );

`ifdef SEQ_PATTERN_TX_PARITY_EN
  // Parity is taken at load time; the shifter loses the word.
  logic par_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^in_if.in_data;
    end
  end
`endif

  // state_q and cnt_q describe the bit currently on x_out.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      x_out      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          x_out <= 1'b0;
          if (accept) begin
            state_q <= SYNC;
            cnt_q   <= CNT_W'(SYNC_LEN - 1);
            x_out   <= SYNC_PAT[SYNC_LEN-1];
          end
        end
        SYNC: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
            x_out <= SYNC_PAT[sidx];
          end else begin
            state_q    <= DATA;
            cnt_q      <= CNT_W'(DATA_W - 1);
            x_out      <= msb;
            frame_done <= LSB_DONE && (DATA_W == 1);
          end
        end
        DATA: begin
          if (cnt_q != '0) begin
            cnt_q      <= cnt_q - 1'b1;
            x_out      <= msb;
            frame_done <= LSB_DONE && (cnt_q == CNT_W'(1));
          end else begin
`ifdef SEQ_PATTERN_TX_PARITY_EN
            state_q    <= PAR;
            x_out      <= par_q;
            frame_done <= 1'b1;
`else
            state_q <= GAP;
            cnt_q   <= CNT_W'(GAP_LEN - 1);
            x_out   <= 1'b0;
`endif
          end
        end
`ifdef SEQ_PATTERN_TX_PARITY_EN
        PAR: begin
          state_q <= GAP;
          cnt_q   <= CNT_W'(GAP_LEN - 1);
          x_out   <= 1'b0;
        end
`endif
        GAP: begin
          x_out <= 1'b0;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          x_out   <= 1'b0;
        end
      endcase
    end
  end

endmodule
